// File: rtl/bus_pkg.sv
// Shared bus definitions: master port state encoding and the ID constants
// the bus controller uses for "no owner".
package bus_pkg;

    localparam int SLAVE_ID_W = 3;
    localparam logic [3:0] MID_NONE = 4'hF;
    localparam logic [SLAVE_ID_W-1:0] SID_NONE = 3'd7;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REQ        = 3'd1,
        OWN        = 3'd2,
        WAIT_RESP  = 3'd3,
        SPLIT_REL  = 3'd4,
        SPLIT_WAIT = 3'd5,
        RESUME     = 3'd6,
        FINISH     = 3'd7
    } mbp_state_t;

endpackage

// File: rtl/mbp_timeout_ctr.sv
// Saturating response-timeout counter; a zero limit never expires.
module mbp_timeout_ctr #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (limit != '0) && (count_q == limit);

endmodule

// File: rtl/master_bus_port.sv
// Per-master front end: turns a core start pulse into the arbiter handshake,
// drives the address phase, and handles split release / re-grant.
module master_bus_port
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_start,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_busy,
    output logic              core_done,
    output logic              core_err,
    output logic [DATA_W-1:0] core_rdata,
    output logic              m_req,
    input  logic              m_grant,
    output logic              bus_util_out,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_rw,
    output logic              bus_valid,
    input  logic              s_ready,
    input  logic              s_split,
    input  logic [DATA_W-1:0] s_rdata
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    mbp_state_t        state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              ctr_clear;
    logic              ctr_en;
    logic              ctr_expired;

    mbp_timeout_ctr #(
        .CNT_W (8)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .limit   (TIMEOUT_LIM),
        .expired (ctr_expired)
    );

    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        ctr_clear    = 1'b1;
        ctr_en       = 1'b0;
        core_busy    = 1'b0;
        core_done    = 1'b0;
        core_err     = 1'b0;
        m_req        = 1'b0;
        bus_util_out = 1'b0;
        bus_addr     = '0;
        bus_wdata    = '0;
        bus_rw       = 1'b0;
        bus_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                if (core_start) begin
                    rw_d    = core_rw;
                    addr_d  = core_addr;
                    wdata_d = core_wdata;
                    err_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                core_busy = 1'b1;
                m_req     = 1'b1;
                if (m_grant) begin
                    state_d = OWN;
                end
            end
            OWN: begin
                core_busy    = 1'b1;
                bus_util_out = 1'b1;
                bus_valid    = 1'b1;
                bus_addr     = addr_q;
                bus_wdata    = wdata_q;
                bus_rw       = rw_q;
                state_d      = WAIT_RESP;
            end
            WAIT_RESP: begin
                core_busy    = 1'b1;
                bus_util_out = 1'b1;
                ctr_clear    = 1'b0;
                ctr_en       = 1'b1;
                // Ready beats split beats timeout when they coincide.
                if (s_ready) begin
                    if (!rw_q) begin
                        rdata_d = s_rdata;
                    end
                    state_d = FINISH;
                end else if (s_split) begin
                    state_d = SPLIT_REL;
                end else if (ctr_expired) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            SPLIT_REL: begin
                core_busy = 1'b1;
                state_d   = SPLIT_WAIT;
            end
            SPLIT_WAIT: begin
                // A grant here is the split re-grant; no request is raised.
                core_busy = 1'b1;
                if (m_grant) begin
                    state_d = RESUME;
                end
            end
            RESUME: begin
                core_busy    = 1'b1;
                bus_util_out = 1'b1;
                ctr_clear    = 1'b0;
                ctr_en       = 1'b1;
                if (s_ready) begin
                    if (!rw_q) begin
                        rdata_d = s_rdata;
                    end
                    state_d = FINISH;
                end else if (ctr_expired) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                core_done = 1'b1;
                core_err  = err_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign core_rdata = rdata_q;

endmodule

// File: tb/tb_master_bus_port.sv
// Self-checking bench for master_bus_port: vector table of transactions plus
// a hand-written reset-abort sequence; expected results go through a queue.
module tb_master_bus_port;

    localparam int M_READY  = 0;
    localparam int M_SPLIT  = 1;
    localparam int M_SILENT = 2;
    localparam int M_BOTH   = 3;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          gdly;
        int          mode;
        int          rdly;
        logic [7:0]  srd;
        logic        ign;
        logic        exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_start = 1'b0;
    logic        core_rw = 1'b0;
    logic [15:0] core_addr = '0;
    logic [7:0]  core_wdata = '0;
    logic        core_busy, core_done, core_err;
    logic [7:0]  core_rdata;
    logic        m_req;
    logic        m_grant = 1'b0;
    logic        bus_util_out;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rw, bus_valid;
    logic        s_ready = 1'b0;
    logic        s_split = 1'b0;
    logic [7:0]  s_rdata = '0;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    master_bus_port #(
        .ADDR_W  (16),
        .DATA_W  (8),
        .TIMEOUT (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_start   (core_start),
        .core_rw      (core_rw),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_busy    (core_busy),
        .core_done    (core_done),
        .core_err     (core_err),
        .core_rdata   (core_rdata),
        .m_req        (m_req),
        .m_grant      (m_grant),
        .bus_util_out (bus_util_out),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rw       (bus_rw),
        .bus_valid    (bus_valid),
        .s_ready      (s_ready),
        .s_split      (s_split),
        .s_rdata      (s_rdata)
    );

    function automatic logic [63:0] all_outs();
        return {25'd0, core_busy, core_done, core_err, core_rdata, m_req,
                bus_util_out, bus_addr, bus_wdata, bus_rw, bus_valid};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for core_done, releasing slave/arbiter strobes each cycle.
    task automatic wait_done(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            s_ready = 1'b0;
            s_split = 1'b0;
            m_grant = 1'b0;
            n++;
        end while (!core_done && n < bound);
    endtask

    task automatic start_txn(input logic rw, input logic [15:0] addr, input logic [7:0] wdata);
        @(negedge clk);
        core_start = 1'b1;
        core_rw    = rw;
        core_addr  = addr;
        core_wdata = wdata;
        @(negedge clk);
        core_start = 1'b0;
        core_addr  = 16'hFFFF;
        core_wdata = 8'h00;
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int   n;
        logic bad;
        exp_t e;
        start_txn(v.rw, v.addr, v.wdata);
        sb.push_back('{err: v.exp_err, rdata: v.exp_rdata});
        chk("req_busy", core_busy, 1'b1);
        chk("req_m_req", m_req, 1'b1);
        repeat (v.gdly) @(negedge clk);
        m_grant = 1'b1;
        @(negedge clk);
        m_grant = 1'b0;
        chk("own_valid", bus_valid, 1'b1);
        chk("own_addr", bus_addr, v.addr);
        chk("own_wdata", bus_wdata, v.wdata);
        chk("own_rw", bus_rw, v.rw);
        chk("own_util", bus_util_out, 1'b1);
        chk("own_m_req", m_req, 1'b0);
        s_rdata = v.srd;
        if (v.mode == M_SILENT) begin
            wait_done(30, n);
            chk("timeout_latency", n, 12);
        end else begin
            repeat (v.rdly) @(negedge clk);
            if (v.mode == M_SPLIT) begin
                s_split = 1'b1;
                @(negedge clk);
                s_split = 1'b0;
                chk("split_rel_util", bus_util_out, 1'b0);
                chk("split_rel_m_req", m_req, 1'b0);
                bad = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    if (v.ign && k == 5) begin
                        core_start = 1'b1;
                        core_rw    = 1'b1;
                        core_addr  = 16'hDEAD;
                    end else begin
                        core_start = 1'b0;
                    end
                    @(negedge clk);
                    if (m_req || bus_util_out || bus_valid || core_done) bad = 1'b1;
                end
                core_start = 1'b0;
                chk("split_wait_quiet", bad, 1'b0);
                m_grant = 1'b1;
                @(negedge clk);
                m_grant = 1'b0;
                chk("resume_util", bus_util_out, 1'b1);
                chk("resume_no_valid", bus_valid, 1'b0);
                chk("resume_m_req", m_req, 1'b0);
            end
            s_ready = 1'b1;
            s_split = (v.mode == M_BOTH);
            wait_done(30, n);
            chk("done_latency", n, 1);
        end
        chk("done", core_done, 1'b1);
        chk("finish_util", bus_util_out, 1'b0);
        chk("finish_busy", core_busy, 1'b0);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("err", core_err, e.err);
            chk("rdata", core_rdata, e.rdata);
        end
        $display("txn %0d rw=%0b addr=%h wdata=%h mode=%0d err=%0b rdata=%h",
                 idx, v.rw, v.addr, v.wdata, v.mode, core_err, core_rdata);
        @(negedge clk);
        chk("done_one_cycle", core_done, 1'b0);
        chk("idle_m_req", m_req, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h2004, 8'hA5, 3, M_READY,  1,  8'h77, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 16'h4010, 8'h00, 1, M_SPLIT,  2,  8'h3C, 1'b1, 1'b0, 8'h3C};
        vecs[2] = '{1'b0, 16'h6020, 8'h00, 0, M_SILENT, 0,  8'hEE, 1'b0, 1'b1, 8'h3C};
        vecs[3] = '{1'b0, 16'h0100, 8'h00, 2, M_BOTH,   1,  8'h5A, 1'b0, 1'b0, 8'h5A};
        vecs[4] = '{1'b1, 16'h8008, 8'h11, 0, M_READY,  3,  8'h99, 1'b0, 1'b0, 8'h5A};
        vecs[5] = '{1'b0, 16'hA0FF, 8'h00, 1, M_READY,  11, 8'hC3, 1'b0, 1'b0, 8'hC3};
        vecs[6] = '{1'b0, 16'h1234, 8'h00, 0, M_READY,  1,  8'hE7, 1'b0, 1'b0, 8'hE7};

        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(i, vecs[i]);
        end

        // Reset while waiting for the slave: everything drops, no done.
        start_txn(1'b0, 16'h3333, 8'h00);
        m_grant = 1'b1;
        @(negedge clk);
        m_grant = 1'b0;
        chk("rst_seq_valid", bus_valid, 1'b1);
        @(negedge clk);
        chk("rst_seq_wait_util", bus_util_out, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        chk("post_reset_no_done", core_done, 1'b0);
        chk("post_reset_no_req", m_req, 1'b0);
        $display("txn reset rw=0 addr=3333 aborted rdata=%h", core_rdata);

        run_txn(6, vecs[6]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
